// File: rtl/f1_light_sequencer.sv
// f1_light_sequencer: F1 start-light sequencer with LFSR-randomised hold before lights out
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   tick       one-cycle step strobe from the tick generator
//   trigger    start request, level sampled every clk while idle
//   abort      synchronous cancel, wins over tick and trigger
//   data_out   light pattern, bit0 lights first
//   busy       high while filling or holding
//   lights_out one-cycle pulse when the lights extinguish
//   hold_ticks hold length captured for the current run
module f1_light_sequencer #(
  parameter int                 N_LIGHTS  = 8,
  parameter int                 DELAY_W   = 7,
  parameter logic [DELAY_W-1:0] LFSR_TAPS = 7'b1100000,
  parameter logic [DELAY_W-1:0] LFSR_SEED = 7'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                trigger,
  input  logic                abort,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                lights_out,
  output logic [DELAY_W-1:0]  hold_ticks
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);
  state_t              state_q, state_d;
  logic [N_LIGHTS-1:0] data_q, data_d;
  logic                busy_q, busy_d;
  logic                lo_q, lo_d;
  logic [DELAY_W-1:0]  hold_ticks_q, hold_ticks_d;
  logic [DELAY_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DELAY_W-1:0]  lfsr_q, lfsr_d;
  // Free-running Fibonacci LFSR; a nonzero seed keeps it out of the all-zero lockup state.
  assign lfsr_d = {lfsr_q[DELAY_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    hold_cnt_d   = hold_cnt_q;
    hold_ticks_d = hold_ticks_q;
    lo_d         = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      data_d     = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          data_d  = '0;
          state_d = trigger ? FILL : IDLE;
        end
        FILL: if (tick) begin
          data_d = {data_q[N_LIGHTS-2:0], 1'b1};
          // This tick lights the last lamp: latch the random hold length now.
          if (&data_q[N_LIGHTS-2:0]) begin
            hold_cnt_d   = lfsr_q;
            hold_ticks_d = lfsr_q;
            state_d      = HOLD;
          end
        end
        HOLD: if (tick) begin
          hold_cnt_d = hold_cnt_q - ONE;
          if (hold_cnt_q == ONE) begin
            data_d  = '0;
            lo_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = '0;
        end
      endcase
    end
  end
  // busy is registered from the next state so it lines up with data_out.
  assign busy_d = (state_d != IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      busy_q       <= 1'b0;
      lo_q         <= 1'b0;
      hold_ticks_q <= '0;
      hold_cnt_q   <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      lo_q         <= lo_d;
      hold_ticks_q <= hold_ticks_d;
      hold_cnt_q   <= hold_cnt_d;
      lfsr_q       <= lfsr_d;
    end
  end
  assign data_out   = data_q;
  assign busy       = busy_q;
  assign lights_out = lo_q;
  assign hold_ticks = hold_ticks_q;
endmodule

// File: tb/tb_f1_light_sequencer.sv
// tb_f1_light_sequencer: directed self-checking bench for the F1 light sequencer
module tb_f1_light_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, trigger = 1'b0, abort = 1'b0;
  logic [7:0] data_out;
  logic       busy, lights_out;
  logic [6:0] hold_ticks;
  logic       rst2_n = 1'b0, tick2 = 1'b0, trig2 = 1'b0, abort2 = 1'b0;
  logic [1:0] data2;
  logic       busy2, lo2;
  logic [2:0] hold2;
  logic [6:0] m_lfsr;
  logic [6:0] pre;
  int         n_cmp = 0, n_err = 0;
  int         h, h1, h_prev, h2;
  logic       done;
  logic       seen [8];
  logic [2:0] exp2 [7] = '{3'd3, 3'd7, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5};

  f1_light_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .trigger(trigger), .abort(abort),
    .data_out(data_out), .busy(busy), .lights_out(lights_out), .hold_ticks(hold_ticks)
  );

  f1_light_sequencer #(.N_LIGHTS(2), .DELAY_W(3), .LFSR_TAPS(3'b110), .LFSR_SEED(3'h1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .tick(tick2), .trigger(trig2), .abort(abort2),
    .data_out(data2), .busy(busy2), .lights_out(lo2), .hold_ticks(hold2)
  );

  always #5 clk = ~clk;

  // Reference LFSR for the 8-light instance (x^7+x^6+1, seed 1).
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 7'h01;
    else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic t, input logic tr, input logic ab);
    @(negedge clk);
    tick = t; trigger = tr; abort = ab; pre = m_lfsr;
    @(posedge clk);
    #1;
  endtask

  // Fill 8 lights then hold; mode 0 no trigger, 1 trigger pulses, 2 trigger held high.
  task automatic fill_and_hold(input int mode, output int hh);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (mode == 2) || (mode == 1 && i[0]), 1'b0);
      chk("fill_data", data_out, 32'((1 << (i + 1)) - 1));
      chk("fill_busy", busy, 1);
      chk("fill_lo", lights_out, 0);
    end
    hh = int'(pre);
    chk("hold_capture", hold_ticks, pre);
    for (int k = 1; k <= hh; k++) begin
      cyc(1'b1, (mode == 2) || (mode == 1 && k[0]), 1'b0);
      if (k < hh) begin
        chk("hold_data", data_out, 8'hFF);
        chk("hold_lo", lights_out, 0);
      end else begin
        chk("out_lo", lights_out, 1);
        chk("out_data", data_out, 0);
        chk("out_busy", busy, 0);
      end
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lo", lights_out, 0);
    chk("rst_hold", hold_ticks, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // test 1/2: basic run, first hold is lfsr step 9 from seed = 12
    cyc(1'b0, 1'b1, 1'b0);
    chk("entry_busy", busy, 1);
    chk("entry_data", data_out, 0);
    fill_and_hold(0, h1);
    chk("first_hold", hold_ticks, 7'd12);
    cyc(1'b0, 1'b0, 1'b0);
    chk("after_lo", lights_out, 0);
    chk("after_busy", busy, 0);
    // test 3: trigger pulses while busy are ignored
    cyc(1'b0, 1'b1, 1'b0);
    fill_and_hold(1, h);
    cyc(1'b0, 1'b0, 1'b0);
    chk("pulse_idle", busy, 0);
    // continuous trigger: back-to-back runs, one IDLE cycle between
    cyc(1'b0, 1'b1, 1'b0);
    fill_and_hold(2, h);
    cyc(1'b0, 1'b1, 1'b0);
    chk("retrig_busy", busy, 1);
    chk("retrig_lo", lights_out, 0);
    chk("retrig_data", data_out, 0);
    fill_and_hold(2, h_prev);
    cyc(1'b0, 1'b0, 1'b0);
    chk("retrig_end", busy, 0);
    // test 4a: abort at 07, with tick and trigger in the same cycle
    cyc(1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_abort", data_out, 8'h07);
    cyc(1'b1, 1'b1, 1'b1);
    chk("abort_data", data_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lo", lights_out, 0);
    chk("abort_hold", hold_ticks, h_prev);
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_stay", busy, 0);
    cyc(1'b0, 1'b1, 1'b0);
    fill_and_hold(0, h);
    // test 4b: abort mid-HOLD
    cyc(1'b0, 1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    h = int'(pre);
    chk("mid_hold_cap", hold_ticks, pre);
    repeat (h / 2) cyc(1'b1, 1'b0, 1'b0);
    chk("mid_hold_data", data_out, 8'hFF);
    cyc(1'b1, 1'b0, 1'b1);
    chk("habort_data", data_out, 0);
    chk("habort_busy", busy, 0);
    chk("habort_lo", lights_out, 0);
    chk("habort_hold", hold_ticks, h);
    cyc(1'b1, 1'b0, 1'b0);
    chk("habort_nolo", lights_out, 0);
    cyc(1'b0, 1'b1, 1'b0);
    fill_and_hold(0, h);
    // test 5: asynchronous reset mid-HOLD between clock edges
    cyc(1'b0, 1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    tick = 1'b0; trigger = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lo", lights_out, 0);
    chk("arst_hold", hold_ticks, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    fill_and_hold(0, h);
    chk("reseed_hold", hold_ticks, h1);
    // test 6: 2 lights, 3-bit LFSR; the idle gap is chosen so each run captures the next LFSR state
    for (int v = 0; v < 8; v++) seen[v] = 1'b0;
    tick2 = 1'b1;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      trig2 = 1'b1;
      @(negedge clk);
      trig2 = 1'b0;
      h2 = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(posedge clk);
        #1;
        if (data2 == 2'b11 && h2 == 0) h2 = int'(hold2);
        done = lo2;
      end
      chk("sweep_done", done, 1);
      chk("sweep_hold", hold2, exp2[r]);
      chk("sweep_nonzero", hold2 != 3'd0, 1);
      chk("sweep_idle", {busy2, data2}, 0);
      seen[hold2] = 1'b1;
      repeat ((12 - h2) % 7) @(posedge clk);
    end
    for (int v = 1; v < 8; v++) chk("sweep_seen", seen[v], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
